// File: rtl/outbuffer_uart_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// outbuffer_uart_pkg: packet constants, state encodings, payload checksum. Rev 1.0
// ----------------------------------------------------------------------------
package outbuffer_uart_pkg;

  localparam int unsigned UART_PKT_BYTES    = 10;
  localparam logic [7:0]  SYNC_BYTE_DEFAULT = 8'hA5;

  // Bit-level states of a single UART frame (ST_LOAD belongs to the packet view).
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_DATA  = 3'd3,
    ST_STOP  = 3'd4
  } tx_state_e;

  // Packet sequencer states; PKT_SEND covers START/DATA/STOP of all ten bytes.
  typedef enum logic [1:0] {
    PKT_IDLE = 2'd0,
    PKT_LOAD = 2'd1,
    PKT_SEND = 2'd2
  } pkt_state_e;

  function automatic logic [7:0] xor_checksum(input logic [63:0] word);
    logic [7:0] acc;
    acc = 8'h00;
    for (int i = 0; i < 8; i++) begin
      acc = acc ^ word[8*i +: 8];
    end
    return acc;
  endfunction

endpackage
`default_nettype wire

// File: rtl/outbuffer_uart_tx_byte.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_byte_tx: one 8N1 frame per start strobe, chainable with no gap. Rev 1.0
// ----------------------------------------------------------------------------
module uart_byte_tx
  import outbuffer_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       done
);

  localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);

  tx_state_e   state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shreg_q, shreg_d;
  logic        tx_q, tx_d;
  logic        bit_end;

  assign bit_end = (cnt_q == BIT_LAST);
  assign tx      = tx_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 16'd0;
      bit_idx_q <= 3'd0;
      shreg_q   <= 8'h00;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
      tx_q      <= tx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_START;
          cnt_d   = 16'd0;
          shreg_d = data;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_d   = ST_DATA;
          cnt_d     = 16'd0;
          bit_idx_d = 3'd0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          cnt_d   = 16'd0;
          shreg_d = {1'b0, shreg_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          cnt_d = 16'd0;
          // A strobe on the last stop cycle chains the next frame without an idle bit.
          if (start) begin
            state_d = ST_START;
            shreg_d = data;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Line level is registered from the next state so the pin never glitches.
  always_comb begin
    done = (state_q == ST_STOP) && bit_end;
    tx_d = 1'b1;
    if (state_d == ST_START) begin
      tx_d = 1'b0;
    end else if (state_d == ST_DATA) begin
      tx_d = shreg_d[0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/outbuffer_uart_tx.sv
`default_nettype none
// ----------------------------------------------------------------------------
// outbuffer_uart_tx: change/refresh-triggered UART packetiser for the result word. Rev 1.0
// ----------------------------------------------------------------------------
module outbuffer_uart_tx
  import outbuffer_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned REFRESH_CLKS = 5_000_000,
  parameter logic [7:0]  SYNC_BYTE    = SYNC_BYTE_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [63:0] outbuffer,
  output logic        uart_tx,
  output logic        busy,
  output logic [15:0] pkt_count,
  output logic [15:0] overrun_count
);

  localparam logic [31:0] REFRESH_LAST = (REFRESH_CLKS == 0) ? 32'd0 : 32'(REFRESH_CLKS - 1);
  localparam logic [3:0]  LAST_BYTE    = 4'(UART_PKT_BYTES - 1);

  pkt_state_e  pkt_state_q, pkt_state_d;
  logic [63:0] in_q, in_prev_q;
  logic [63:0] last_sent_q, last_sent_d;
  logic [63:0] shadow_q, shadow_d;
  logic [7:0]  csum_q, csum_d;
  logic [3:0]  byte_idx_q, byte_idx_d;
  logic [31:0] refresh_q, refresh_d;
  logic [15:0] pkt_count_q, pkt_count_d;
  logic [15:0] overrun_q, overrun_d;

  logic        refresh_hit, send_req;
  logic [3:0]  next_byte;
  logic [7:0]  payload_byte;
  logic        byte_start, byte_done;
  logic [7:0]  byte_data;

  assign refresh_hit   = (REFRESH_CLKS != 0) && (refresh_q == REFRESH_LAST);
  assign send_req      = enable && ((in_q != last_sent_q) || refresh_hit);
  assign next_byte     = byte_idx_q + 4'd1;
  assign busy          = (pkt_state_q != PKT_IDLE);
  assign pkt_count     = pkt_count_q;
  assign overrun_count = overrun_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pkt_state_q <= PKT_IDLE;
      in_q        <= 64'h0;
      in_prev_q   <= 64'h0;
      last_sent_q <= 64'h0;
      shadow_q    <= 64'h0;
      csum_q      <= 8'h00;
      byte_idx_q  <= 4'd0;
      refresh_q   <= 32'd0;
      pkt_count_q <= 16'd0;
      overrun_q   <= 16'd0;
    end else begin
      pkt_state_q <= pkt_state_d;
      in_q        <= outbuffer;
      in_prev_q   <= in_q;
      last_sent_q <= last_sent_d;
      shadow_q    <= shadow_d;
      csum_q      <= csum_d;
      byte_idx_q  <= byte_idx_d;
      refresh_q   <= refresh_d;
      pkt_count_q <= pkt_count_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    pkt_state_d = pkt_state_q;
    unique case (pkt_state_q)
      PKT_IDLE: if (send_req) pkt_state_d = PKT_LOAD;
      PKT_LOAD: pkt_state_d = PKT_SEND;
      PKT_SEND: if (byte_done && (byte_idx_q == LAST_BYTE)) pkt_state_d = PKT_IDLE;
      default:  pkt_state_d = PKT_IDLE;
    endcase
  end

  // Bytes 1..8 walk the snapshot MSB first; anything past that is the checksum.
  always_comb begin
    payload_byte = csum_q;
    for (int i = 1; i <= 8; i++) begin
      if (next_byte == 4'(i)) payload_byte = shadow_q[8*(8-i) +: 8];
    end
  end

  always_comb begin
    last_sent_d = last_sent_q;
    shadow_d    = shadow_q;
    csum_d      = csum_q;
    byte_idx_d  = byte_idx_q;
    refresh_d   = refresh_q;
    pkt_count_d = pkt_count_q;
    overrun_d   = overrun_q;
    byte_start  = 1'b0;
    byte_data   = SYNC_BYTE;
    unique case (pkt_state_q)
      PKT_IDLE: begin
        if (send_req) begin
          refresh_d = 32'd0;
        end else if ((REFRESH_CLKS != 0) && !refresh_hit) begin
          refresh_d = refresh_q + 32'd1;
        end
      end
      PKT_LOAD: begin
        shadow_d    = in_q;
        last_sent_d = in_q;
        csum_d      = xor_checksum(in_q);
        byte_idx_d  = 4'd0;
        refresh_d   = 32'd0;
        byte_start  = 1'b1;
      end
      PKT_SEND: begin
        if (byte_done) begin
          if (byte_idx_q != LAST_BYTE) begin
            byte_idx_d = next_byte;
            byte_start = 1'b1;
            byte_data  = payload_byte;
          end else begin
            pkt_count_d = pkt_count_q + 16'd1;
            refresh_d   = 32'd0;
          end
        end
      end
      default: ;
    endcase
    // An unsent value being replaced while the line is occupied is lost.
    if (busy && (in_q != in_prev_q) && (in_prev_q != last_sent_q) && (overrun_q != 16'hFFFF)) begin
      overrun_d = overrun_q + 16'd1;
    end
  end

  uart_byte_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte_tx (
    .clk    (clk),
    .reset_n(reset_n),
    .start  (byte_start),
    .data   (byte_data),
    .tx     (uart_tx),
    .done   (byte_done)
  );

endmodule
`default_nettype wire
